fifo_sync_bram: RTL and testbench

- Parametrised single-clock FIFO built on an inferred simple-dual-port block RAM.
- Generalised successor to the fixed 6-bit-address / 8-bit-data fifo RAM wrapper.
- Adds pointer management, occupancy count, full/empty and programmable almost-full/almost-empty flags, and overflow/underflow error pulses.
- Sits between a producer and a consumer in the same clock domain; it is the standard buffer for stream bridges.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/bram_sdp_sync.sv | 31 +++
 rtl/fifo_sync_bram.sv | 124 ++++++++++++
 tb/tb_fifo_sync_bram.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the BRAM-backed synchronous FIFO.
package fifo_pkg;

  // Address width used when the FIFO is instantiated without overrides.
  localparam int DEF_ADDR = 6;

  // Occupancy type for the default geometry: one bit wider than the address
  // so that a completely full FIFO (DEPTH words) is representable.
  typedef logic [DEF_ADDR:0] count_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Number of words addressed by an ADDR-bit pointer.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/bram_sdp_sync.sv
// Simple-dual-port RAM, one clock, registered read port. The contents are
// never reset, so synthesis maps this onto a block RAM primitive.
module bram_sdp_sync #(
  parameter int DATA = 8,
  parameter int ADDR = 6
) (
  input  logic            clk,
  input  logic            we,
  input  logic [ADDR-1:0] waddr,
  input  logic [DATA-1:0] wdata,
  input  logic            re,
  input  logic [ADDR-1:0] raddr,
  output logic [DATA-1:0] rdata
);

  logic [DATA-1:0] mem [2**ADDR];
  logic [DATA-1:0] rdata_q;

  // Write port and registered read port; rdata holds while re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_sync_bram.sv
// Single-clock FIFO around bram_sdp_sync: pointers, occupancy count,
// full/empty and programmable almost flags, overflow/underflow pulses.
module fifo_sync_bram
  import fifo_pkg::*;
#(
  parameter int DATA      = 8,
  parameter int ADDR      = 6,
  parameter int AFULL_TH  = (2**ADDR) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  output logic            full,
  output logic            almost_full,
  input  logic            rd_en,
  output logic [DATA-1:0] rd_data,
  output logic            rd_valid,
  output logic            empty,
  output logic            almost_empty,
  output logic [ADDR:0]   count,
  output logic            overflow,
  output logic            underflow
);

  localparam int DEPTH = fifo_depth(ADDR);

  typedef logic [ADDR:0]   cnt_t;
  typedef logic [ADDR-1:0] ptr_t;

  localparam cnt_t DEPTH_C     = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C     = cnt_t'(AFULL_TH);
  localparam cnt_t AEMPTY_C    = cnt_t'(AEMPTY_TH);

  // Reject geometries and thresholds the flag decode cannot honour.
  if (DATA < 1 || ADDR < 2 || clog2(DEPTH) != ADDR) begin : g_bad_geometry
    $error("fifo_sync_bram: DATA must be >= 1 and ADDR >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_sync_bram: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync_bram: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic rd_valid_q, rd_valid_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;
  logic wr_acc, rd_acc;

  // Flags are pure decodes of the registered count.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);

  // Accept decisions, pointer/count next state and error pulses. A full FIFO
  // refuses writes even when a read frees a slot in the same cycle, and an
  // empty FIFO refuses reads, so the RAM never sees same-address read/write.
  always_comb begin
    wr_acc      = wr_en & ~full;
    rd_acc      = rd_en & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_acc;
    overflow_d  = wr_en & full;
    underflow_d = rd_en & empty;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (wr_acc && !rd_acc) begin
      count_d = count_q + cnt_t'(1);
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  // Control state; reset also kills any read whose data is still in the RAM
  // output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  bram_sdp_sync #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_sync_bram.sv
// Bench for fifo_sync_bram (DATA=8, ADDR=4): queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_fifo_sync_bram;

  localparam int DATA  = 8;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;
  localparam int AF_TH = 14;
  localparam int AE_TH = 2;

  logic            clk;
  logic            rst;
  logic            wr_en;
  logic [DATA-1:0] wr_data;
  logic            full;
  logic            almost_full;
  logic            rd_en;
  logic [DATA-1:0] rd_data;
  logic            rd_valid;
  logic            empty;
  logic            almost_empty;
  logic [ADDR:0]   count;
  logic            overflow;
  logic            underflow;

  int checks = 0;
  int errors = 0;

  fifo_sync_bram #(
    .DATA      (DATA),
    .ADDR      (ADDR),
    .AFULL_TH  (AF_TH),
    .AEMPTY_TH (AE_TH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the expected pulses.
  logic [DATA-1:0] q[$];
  logic            exp_rv;
  logic [DATA-1:0] exp_rd;
  logic            exp_ovf;
  logic            exp_udf;

  initial begin
    exp_rv  = 1'b0;
    exp_rd  = '0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      exp_rv  = 1'b0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      exp_rv  = rd_en && !was_empty;
      exp_ovf = wr_en && was_full;
      exp_udf = rd_en && was_empty;
      if (exp_rv) exp_rd = q.pop_front();
      if (wr_en && !was_full) q.push_back(wr_data);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == DEPTH));
      chk("m_almost_full", 32'(almost_full), 32'(q.size() >= AF_TH));
      chk("m_almost_empty", 32'(almost_empty), 32'(q.size() <= AE_TH));
      chk("m_rd_valid", 32'(rd_valid), 32'(exp_rv));
      chk("m_overflow", 32'(overflow), 32'(exp_ovf));
      chk("m_underflow", 32'(underflow), 32'(exp_udf));
      if (exp_rv) chk("m_rd_data", 32'(rd_data), 32'(exp_rd));
    end
  end

  // Present one cycle of inputs just after an active edge.
  task automatic step(input logic we, input logic [DATA-1:0] wd, input logic re);
    @(posedge clk);
    #1;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    repeat (5) step(1'b0, 8'h00, 1'b0);

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_afull", 32'(almost_full), 32'(i >= 14));
    end
    step(1'b0, 8'h00, 1'b0);
    chk("full_count", 32'(count), 32'd16);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_afull", 32'(almost_full), 32'd1);

    // Drain; each word appears one cycle after its rd_en
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_aempty", 32'(almost_empty), 32'((16 - i) <= 2));
      if (i > 0) begin
        chk("drain_valid", 32'(rd_valid), 32'd1);
        chk("drain_data", 32'(rd_data), 32'(i - 1));
      end
    end
    step(1'b0, 8'h00, 1'b0);
    chk("drain_last_data", 32'(rd_data), 32'h0F);
    chk("drain_empty", 32'(empty), 32'd1);

    // Full with simultaneous write and read: write dropped
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd15);
    chk("ovf_rd_data", 32'(rd_data), 32'h00);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 8'h00, 1'b1);
      if (i > 0) chk("ovf_drain_data", 32'(rd_data), 32'(i));
    end
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_drain_last", 32'(rd_data), 32'h0F);
    chk("ovf_drain_empty", 32'(empty), 32'd1);

    // Empty with simultaneous write and read: read dropped
    step(1'b1, 8'h55, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("udf_pulse", 32'(underflow), 32'd1);
    chk("udf_count", 32'(count), 32'd1);
    chk("udf_no_valid", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("udf_read_valid", 32'(rd_valid), 32'd1);
    chk("udf_read_data", 32'(rd_data), 32'h55);

    // Pointer wrap: hold occupancy at 8 through 40 write/read pairs
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
    for (int j = 0; j < 40; j++) begin
      step(1'b1, 8'(8 + j), 1'b1);
      if (j > 0) chk("wrap_data", 32'(rd_data), 32'(j - 1));
    end
    step(1'b0, 8'h00, 1'b0);
    chk("wrap_last_data", 32'(rd_data), 32'd39);
    chk("wrap_count", 32'(count), 32'd8);

    // Reset while a read result is on the output
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    chk("pre_rst_count", 32'(count), 32'd5);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    rst   = 1'b1;
    rd_en = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h33, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_valid", 32'(rd_valid), 32'd1);
    chk("post_rst_data", 32'(rd_data), 32'h33);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
